// File: rtl/mul_pipe_pkg.sv
// mul_pipe shared state encoding and product-fitting constants.
// Define MUL_PIPE_SATURATE_EN to clamp products instead of truncating.
package mul_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

`ifdef MUL_PIPE_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Two guard bits keep unsigned operands positive inside a signed multiply.
  localparam int PROD_GUARD = 2;

  function automatic int prod_width(input int dw);
    return 2 * dw + PROD_GUARD;
  endfunction

endpackage

// File: rtl/mul_pipe_fifo.sv
// Activation group FIFO with show-ahead read data and full/almost-full flags.
module mul_pipe_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full
);
  localparam int AW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [AW-1:0] LAST = AW'(NUM_SLOTS - 1);

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop;

  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign empty = (count == '0);
  assign full = (count == (AW+1)'(NUM_SLOTS));
  assign almost_full = (count == (AW+1)'(NUM_SLOTS - 1));
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Grouped activation x weight multiplier, two-stage pipeline, IDLE/RUN/DRAIN.
// MUL_PIPE_SATURATE_EN (see mul_pipe_pkg) selects clamped products.
module mul_pipe
  import mul_pipe_pkg::*;
#(
  parameter int GROUP_SIZE             = 4,
  parameter int DATA_WIDTH             = 8,
  parameter int OUT_WIDTH              = 16,
  parameter int SIGNED_MODE            = 0,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int FIFO_LOG_SLOTS         = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                configure,
  input  logic [LOG_MAX_ITERS-1:0]            num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]   num_reads_per_iter,
  output logic                                busy,
  output logic                                done,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]    act_data_in,
  input  logic                                act_valid_in,
  output logic                                act_avail_out,
  input  logic [DATA_WIDTH-1:0]               weight_data_in,
  input  logic                                weight_valid_in,
  output logic                                weight_avail_out,
  output logic [GROUP_SIZE*OUT_WIDTH-1:0]     data_out,
  output logic                                valid_out,
  input  logic                                avail_in
);
  localparam int PW = prod_width(DATA_WIDTH);
  localparam int GW = GROUP_SIZE * DATA_WIDTH;
  localparam int OW = GROUP_SIZE * OUT_WIDTH;
  localparam logic [LOG_MAX_ITERS-1:0] I_ONE = LOG_MAX_ITERS'(1);
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] R_ONE =
    LOG_MAX_READS_PER_ITER'(1);
  localparam logic signed [PW-1:0] P_ONE = PW'(1);
  localparam logic signed [PW-1:0] S_MAX = (P_ONE <<< (OUT_WIDTH - 1)) - P_ONE;
  localparam logic signed [PW-1:0] S_MIN = -(P_ONE <<< (OUT_WIDTH - 1));
  localparam logic signed [PW-1:0] U_MAX = (P_ONE <<< OUT_WIDTH) - P_ONE;

  state_t state, state_nx;
  logic fifo_empty, fifo_full, fifo_afull;
  logic [GW-1:0] fifo_data;
  logic [DATA_WIDTH-1:0] act_w, pend_w;
  logic act_v, pend_v;
  logic [LOG_MAX_ITERS-1:0] iter_cnt;
  logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt, reads_cfg;
  logic [OW-1:0] prod, s1_data, out_data;
  logic s1_v, out_v, done_r;
  logic cfg_ok, cfg_zero, out_adv, s1_free, rd, iter_end, last_rd;
  logic drained, promote, w_acc;

  function automatic logic [OUT_WIDTH-1:0] fit(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic sa, sb;
    logic signed [PW-1:0] ea, eb, p;
    logic [OUT_WIDTH-1:0] r;
    sa = (SIGNED_MODE != 0) && a[DATA_WIDTH-1];
    sb = (SIGNED_MODE != 0) && b[DATA_WIDTH-1];
    ea = {{(PW-DATA_WIDTH){sa}}, a};
    eb = {{(PW-DATA_WIDTH){sb}}, b};
    p = ea * eb;
    r = p[OUT_WIDTH-1:0];
    if (SAT_EN) begin
      if (SIGNED_MODE != 0) begin
        if (p > S_MAX) r = S_MAX[OUT_WIDTH-1:0];
        else if (p < S_MIN) r = S_MIN[OUT_WIDTH-1:0];
      end else if (p > U_MAX) begin
        r = '1;
      end
    end
    return r;
  endfunction

  mul_pipe_fifo #(
    .DATA_WIDTH(GW),
    .NUM_SLOTS (2 ** FIFO_LOG_SLOTS)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (act_valid_in),
    .wr_data    (act_data_in),
    .rd_en      (rd),
    .rd_data    (fifo_data),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .almost_full(fifo_afull)
  );

  assign cfg_ok = (state == IDLE) && configure &&
                  (num_iters != '0) && (num_reads_per_iter != '0);
  assign cfg_zero = (state == IDLE) && configure && !cfg_ok;
  assign out_adv = !out_v || avail_in;
  assign s1_free = !s1_v || out_adv;
  assign rd = (state == RUN) && !fifo_empty && act_v && s1_free;
  assign iter_end = rd && (read_cnt == R_ONE);
  assign last_rd = iter_end && (iter_cnt == I_ONE);
  assign drained = !s1_v && out_adv;
  // Pending slides into active on an empty active slot or iteration end.
  assign promote = pend_v && (!act_v || iter_end);
  assign w_acc = weight_valid_in && !pend_v;

  always_comb begin
    prod = '0;
    for (int i = 0; i < GROUP_SIZE; i++)
      prod[i*OUT_WIDTH +: OUT_WIDTH] =
        fit(fifo_data[i*DATA_WIDTH +: DATA_WIDTH], act_w);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cfg_ok) state_nx = RUN;
      RUN:     if (last_rd) state_nx = DRAIN;
      DRAIN:   if (drained) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_cnt <= '0;
      read_cnt <= '0;
      reads_cfg <= '0;
    end else if (cfg_ok) begin
      iter_cnt <= num_iters;
      read_cnt <= num_reads_per_iter;
      reads_cfg <= num_reads_per_iter;
    end else if (rd) begin
      if (iter_end) begin
        read_cnt <= reads_cfg;
        iter_cnt <= iter_cnt - I_ONE;
      end else begin
        read_cnt <= read_cnt - R_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_w <= '0;
      act_v <= 1'b0;
      pend_w <= '0;
      pend_v <= 1'b0;
    end else begin
      if (!act_v || iter_end) begin
        act_v <= pend_v;
        if (pend_v) act_w <= pend_w;
      end
      if (w_acc) begin
        pend_w <= weight_data_in;
        pend_v <= 1'b1;
      end else if (promote) begin
        pend_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_data <= '0;
      s1_v <= 1'b0;
      out_data <= '0;
      out_v <= 1'b0;
      done_r <= 1'b0;
    end else begin
      if (rd) begin
        s1_data <= prod;
        s1_v <= 1'b1;
      end else if (out_adv) begin
        s1_v <= 1'b0;
      end
      if (out_adv) begin
        out_v <= s1_v;
        if (s1_v) out_data <= s1_data;
      end
      done_r <= cfg_zero || ((state == DRAIN) && drained);
    end
  end

  assign busy = (state != IDLE);
  assign done = done_r;
  assign act_avail_out = !fifo_afull && !fifo_full;
  assign weight_avail_out = !pend_v;
  assign data_out = out_data;
  assign valid_out = out_v;

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed scenarios plus random runs
// checked against a queue-based arithmetic reference model.
module tb_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, configure, act_valid, weight_valid, avail_in, sel;
  logic [15:0] num_iters, num_reads;
  logic [31:0] act_data;
  logic [7:0] weight_data;
  logic a_busy, a_done, a_aav, a_wav, a_vo;
  logic [63:0] a_do;
  logic b_busy, b_done, b_aav, b_wav, b_vo;
  logic [31:0] b_do;
  logic o_busy, o_done, o_aav, o_wav, o_vo;
  logic [63:0] o_do;

  mul_pipe u_a (
    .clk(clk), .rst(rst), .configure(configure && !sel),
    .num_iters(num_iters), .num_reads_per_iter(num_reads),
    .busy(a_busy), .done(a_done),
    .act_data_in(act_data), .act_valid_in(act_valid && !sel),
    .act_avail_out(a_aav),
    .weight_data_in(weight_data), .weight_valid_in(weight_valid && !sel),
    .weight_avail_out(a_wav),
    .data_out(a_do), .valid_out(a_vo), .avail_in(avail_in)
  );

  mul_pipe #(
    .GROUP_SIZE(4), .DATA_WIDTH(8), .OUT_WIDTH(8), .SIGNED_MODE(1)
  ) u_b (
    .clk(clk), .rst(rst), .configure(configure && sel),
    .num_iters(num_iters), .num_reads_per_iter(num_reads),
    .busy(b_busy), .done(b_done),
    .act_data_in(act_data), .act_valid_in(act_valid && sel),
    .act_avail_out(b_aav),
    .weight_data_in(weight_data), .weight_valid_in(weight_valid && sel),
    .weight_avail_out(b_wav),
    .data_out(b_do), .valid_out(b_vo), .avail_in(avail_in)
  );

  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_aav = sel ? b_aav : a_aav;
  assign o_wav = sel ? b_wav : a_wav;
  assign o_vo = sel ? b_vo : a_vo;
  assign o_do = sel ? {32'b0, b_do} : a_do;

  int vectors = 0;
  int miscompares = 0;
  int step_no = 0;
  int xfers, done_cnt, done_step, last_xfer_step, first_vo_step;
  int w_sent, w_gate, bp_left, av_pct, cfg_step;
  logic [31:0] act_q[$];
  logic [7:0] w_q[$];
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: per-lane integer product, then clamp or keep low bits.
  function automatic logic [63:0] model(input logic [31:0] g,
                                        input logic [7:0] w,
                                        input logic sgn);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int a, b, p;
      logic [7:0] it;
      it = g[i*8 +: 8];
      if (sgn) begin
        a = $signed(it);
        b = $signed(w);
      end else begin
        a = int'(it);
        b = int'(w);
      end
      p = a * b;
      if (sgn) begin
`ifdef MUL_PIPE_SATURATE_EN
        if (p > 127) p = 127;
        else if (p < -128) p = -128;
`endif
        r[i*8 +: 8] = p[7:0];
      end else begin
`ifdef MUL_PIPE_SATURATE_EN
        if (p > 65535) p = 65535;
`endif
        r[i*16 +: 16] = p[15:0];
      end
    end
    return r;
  endfunction

  task automatic new_run();
    xfers = 0; done_cnt = 0; done_step = -1; last_xfer_step = -1;
    first_vo_step = -1; w_sent = 0; w_gate = 0; bp_left = 0;
    av_pct = 100;
  endtask

  // One clock: observe at negedge, drive inputs, advance to next negedge.
  task automatic step();
    if (o_done) begin
      done_cnt++;
      done_step = step_no;
      check("busy_at_done", {63'b0, o_busy}, 64'd0);
    end
    if (o_vo) begin
      if (first_vo_step < 0) first_vo_step = step_no;
      if (exp_q.size() == 0) check("extra_out", {63'b0, o_vo}, 64'd0);
      else check("data_out", o_do, exp_q[0]);
    end
    if (bp_left > 0) begin
      avail_in = 1'b0;
      bp_left--;
    end else begin
      avail_in = (int'($urandom_range(0, 99)) < av_pct);
    end
    if (o_vo && avail_in) begin
      if (exp_q.size() > 0) exp_q.delete(0);
      xfers++;
      last_xfer_step = step_no;
    end
    act_valid = (act_q.size() > 0) && o_aav;
    if (act_valid) act_data = act_q.pop_front();
    else act_data = 32'h0;
    weight_valid = (w_q.size() > 0) && o_wav &&
                   (w_sent == 0 || step_no >= w_gate);
    if (weight_valid) begin
      weight_data = w_q.pop_front();
      w_sent++;
    end else begin
      weight_data = 8'h0;
    end
    @(posedge clk);
    @(negedge clk);
    configure = 1'b0;
    step_no++;
  endtask

  task automatic start(input int iters, input int reads);
    num_iters = 16'(iters);
    num_reads = 16'(reads);
    configure = 1'b1;
    cfg_step = step_no;
    step();
  endtask

  task automatic finish_run(input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || done_cnt == 0) && n < 400) begin
      step();
      n++;
    end
    check({tag, "_complete"}, {63'b0, (n < 400)}, 64'd1);
    check({tag, "_done_lat"}, 64'(done_step), 64'(last_xfer_step + 1));
    step();
    step();
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic build_random(input int iters, input int reads);
    for (int k = 0; k < iters; k++) begin
      logic [7:0] w;
      w = 8'($urandom);
      w_q.push_back(w);
      for (int j = 0; j < reads; j++) begin
        logic [31:0] g;
        g = $urandom;
        act_q.push_back(g);
        exp_q.push_back(model(g, w, sel));
      end
    end
  endtask

  task automatic load_basic();
    repeat (6) act_q.push_back(32'h04030201);
    w_q.push_back(8'd3);
    w_q.push_back(8'd5);
    repeat (3) exp_q.push_back(64'h000c_0009_0006_0003);
    repeat (3) exp_q.push_back(64'h0014_000f_000a_0005);
  endtask

  initial begin
    rst = 1'b0; configure = 1'b0; act_valid = 1'b0; weight_valid = 1'b0;
    avail_in = 1'b1; sel = 1'b0; num_iters = '0; num_reads = '0;
    act_data = '0; weight_data = '0;
    new_run();
    repeat (2) @(negedge clk);
    check("rst_valid", {63'b0, o_vo}, 64'd0);
    check("rst_done", {63'b0, o_done}, 64'd0);
    check("rst_busy", {63'b0, o_busy}, 64'd0);
    check("rst_data", o_do, 64'd0);
    check("rst_act_avail", {63'b0, o_aav}, 64'd1);
    check("rst_w_avail", {63'b0, o_wav}, 64'd1);
    rst = 1'b1;

    // Basic
    new_run();
    load_basic();
    repeat (4) step();
    start(2, 3);
    check("basic_busy", {63'b0, o_busy}, 64'd1);
    finish_run("basic");
    check("basic_first_lat", 64'(first_vo_step), 64'(cfg_step + 3));
    check("basic_xfers", 64'(xfers), 64'd6);

    // Backpressure
    new_run();
    load_basic();
    repeat (4) step();
    start(2, 3);
    repeat (3) step();
    bp_left = 5;
    finish_run("bp");
    check("bp_xfers", 64'(xfers), 64'd6);

    // Weight starvation
    new_run();
    w_gate = step_no + 19;
    load_basic();
    repeat (4) step();
    start(2, 3);
    repeat (12) step();
    check("starve_outs", 64'(xfers), 64'd3);
    check("starve_idle_out", {63'b0, o_vo}, 64'd0);
    check("starve_busy", {63'b0, o_busy}, 64'd1);
    finish_run("starve");

    // Signed -128 x -128 and neighbours
    new_run();
    sel = 1'b1;
    act_q.push_back(32'hff057f80);
    w_q.push_back(8'h80);
`ifdef MUL_PIPE_SATURATE_EN
    exp_q.push_back(64'h0000_0000_7f80_807f);
`else
    exp_q.push_back(64'h0000_0000_8080_8000);
`endif
    start(1, 1);
    finish_run("signed");
    sel = 1'b0;

    // Zero configuration
    for (int z = 0; z < 2; z++) begin
      new_run();
      start(z == 0 ? 0 : 2, z == 0 ? 3 : 0);
      check("zero_done", {63'b0, o_done}, 64'd1);
      check("zero_busy", {63'b0, o_busy}, 64'd0);
      step();
      check("zero_done_once", {63'b0, o_done}, 64'd0);
    end

    // Random runs on both instances
    for (int r = 0; r < 6; r++) begin
      int it, rd;
      new_run();
      sel = r[0];
      av_pct = 60;
      it = int'($urandom_range(1, 3));
      rd = int'($urandom_range(1, 4));
      build_random(it, rd);
      start(it, rd);
      finish_run("random");
    end
    sel = 1'b0;

    // Reset in the middle of a run
    new_run();
    build_random(3, 4);
    start(3, 4);
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    check("mrst_valid", {63'b0, o_vo}, 64'd0);
    check("mrst_done", {63'b0, o_done}, 64'd0);
    check("mrst_busy", {63'b0, o_busy}, 64'd0);
    check("mrst_data", o_do, 64'd0);
    check("mrst_act_avail", {63'b0, o_aav}, 64'd1);
    check("mrst_w_avail", {63'b0, o_wav}, 64'd1);
    act_q.delete();
    w_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (10) step();
    check("mrst_no_done", 64'(done_cnt), 64'd0);

    // Recovery after reset
    new_run();
    build_random(2, 2);
    start(2, 2);
    finish_run("recover");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
